// File: rtl/ppu_regs.sv
// CPU-facing PPU register file: $2000-$3FFF decode (8-byte mirror), loopy scroll
// latches, PPUDATA read buffer, status flags and the NMI level.
module ppu_regs (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_rw_i,
   input  logic [15:0] cpu_addr_i,
   input  logic [7:0]  cpu_data_i,
   output logic [7:0]  cpu_data_o,
   output logic        nmi_o,
   output logic [7:0]  ctrl_o,
   output logic [7:0]  mask_o,
   output logic [14:0] v_o,
   output logic [14:0] t_o,
   output logic [2:0]  fine_x_o,
   input  logic        vblank_set_i,
   input  logic        vblank_clr_i,
   input  logic        spr0_hit_i,
   input  logic        spr_ovf_i,
   input  logic        inc_x_i,
   input  logic        inc_y_i,
   input  logic        copy_x_i,
   input  logic        copy_y_i,
   output logic [7:0]  oam_addr_o,
   output logic        oam_we_o,
   output logic [7:0]  oam_wdata_o,
   input  logic [7:0]  oam_rdata_i,
   output logic [13:0] vram_addr_o,
   output logic        vram_we_o,
   output logic        vram_re_o,
   output logic [7:0]  vram_wdata_o,
   input  logic [7:0]  vram_rdata_i
);

   logic        sel, rd, wr, rd_status, render_en;
   logic [2:0]  reg_sel;
   logic [7:0]  ctrl_reg, ctrl_next, mask_reg, mask_next;
   logic        vblank_reg, vblank_next, spr0_reg, spr0_next, ovf_reg, ovf_next;
   logic        w_reg, w_next;
   logic [14:0] t_reg, t_next, v_reg, v_next, v_rend, v_step;
   logic [2:0]  x_reg, x_next;
   logic [7:0]  oam_addr_reg, oam_addr_next, buf_reg, buf_next;
   logic [13:0] vram_addr_reg, vram_addr_next;
   logic [7:0]  vram_wdata_reg, vram_wdata_next;
   logic        vram_we_reg, vram_we_next, vram_re_reg, vram_re_next;

   // Decoding is suppressed while in reset so no access side effect or pulse can leak out.
   assign sel       = (cpu_addr_i[15:13] == 3'b001) && !rst;
   assign rd        = sel && cpu_rw_i;
   assign wr        = sel && !cpu_rw_i;
   assign reg_sel   = cpu_addr_i[2:0];
   assign rd_status = rd && (reg_sel == 3'd2);
   assign render_en = mask_reg[3] | mask_reg[4];
   assign v_step    = v_reg + (ctrl_reg[2] ? 15'd32 : 15'd1);

   // v layout: fine Y [14:12], nametable Y [11], nametable X [10], coarse Y [9:5], coarse X [4:0]
   always_comb begin
      v_rend = v_reg;
      if (render_en) begin
         if (inc_x_i) begin
            if (v_rend[4:0] == 5'd31) begin
               v_rend[4:0] = 5'd0;
               v_rend[10]  = ~v_rend[10];
            end else begin
               v_rend[4:0] = v_rend[4:0] + 5'd1;
            end
         end
         if (inc_y_i) begin
            if (v_rend[14:12] != 3'd7) begin
               v_rend[14:12] = v_rend[14:12] + 3'd1;
            end else begin
               v_rend[14:12] = 3'd0;
               if (v_rend[9:5] == 5'd29) begin
                  v_rend[9:5] = 5'd0;
                  v_rend[11]  = ~v_rend[11];
               end else if (v_rend[9:5] == 5'd31) begin
                  v_rend[9:5] = 5'd0;
               end else begin
                  v_rend[9:5] = v_rend[9:5] + 5'd1;
               end
            end
         end
         if (copy_x_i) begin
            v_rend[10]  = t_reg[10];
            v_rend[4:0] = t_reg[4:0];
         end
         if (copy_y_i) begin
            v_rend[14:11] = t_reg[14:11];
            v_rend[9:5]   = t_reg[9:5];
         end
      end
   end

   always_comb begin
      ctrl_next       = ctrl_reg;
      mask_next       = mask_reg;
      w_next          = w_reg;
      t_next          = t_reg;
      v_next          = v_rend;
      x_next          = x_reg;
      oam_addr_next   = oam_addr_reg;
      buf_next        = vram_re_reg ? vram_rdata_i : buf_reg;
      vram_addr_next  = vram_addr_reg;
      vram_wdata_next = vram_wdata_reg;
      vram_we_next    = 1'b0;
      vram_re_next    = 1'b0;

      // Clears beat sets; a status read coincident with the set suppresses it.
      vblank_next = vblank_set_i ? 1'b1 : vblank_reg;
      if (vblank_clr_i || rd_status) vblank_next = 1'b0;
      spr0_next = (spr0_reg | spr0_hit_i) & ~vblank_clr_i;
      ovf_next  = (ovf_reg | spr_ovf_i) & ~vblank_clr_i;

      if (wr) begin
         case (reg_sel)
            3'd0: begin
               ctrl_next      = cpu_data_i;
               t_next[11:10]  = cpu_data_i[1:0];
            end
            3'd1: mask_next     = cpu_data_i;
            3'd3: oam_addr_next = cpu_data_i;
            3'd4: oam_addr_next = oam_addr_reg + 8'd1;
            3'd5: begin
               if (!w_reg) begin
                  t_next[4:0] = cpu_data_i[7:3];
                  x_next      = cpu_data_i[2:0];
               end else begin
                  t_next[14:12] = cpu_data_i[2:0];
                  t_next[9:5]   = cpu_data_i[7:3];
               end
               w_next = ~w_reg;
            end
            3'd6: begin
               if (!w_reg) begin
                  t_next[13:8] = cpu_data_i[5:0];
                  t_next[14]   = 1'b0;
               end else begin
                  t_next[7:0] = cpu_data_i;
                  v_next      = {t_reg[14:8], cpu_data_i};
               end
               w_next = ~w_reg;
            end
            3'd7: begin
               vram_we_next    = 1'b1;
               vram_addr_next  = v_reg[13:0];
               vram_wdata_next = cpu_data_i;
               v_next          = v_step;
            end
            default: ;
         endcase
      end else if (rd) begin
         if (reg_sel == 3'd2) w_next = 1'b0;
         if (reg_sel == 3'd7) begin
            vram_re_next   = 1'b1;
            vram_addr_next = v_reg[13:0];
            v_next         = v_step;
         end
      end
   end

   always_comb begin
      cpu_data_o = 8'h00;
      if (rd) begin
         case (reg_sel)
            3'd0:    cpu_data_o = ctrl_reg;
            3'd1:    cpu_data_o = mask_reg;
            3'd2:    cpu_data_o = {vblank_reg & ~vblank_set_i, spr0_reg, ovf_reg, 5'b00000};
            3'd4:    cpu_data_o = oam_rdata_i;
            3'd7:    cpu_data_o = buf_reg;
            default: cpu_data_o = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_reg       <= 8'h00;
         mask_reg       <= 8'h00;
         vblank_reg     <= 1'b0;
         spr0_reg       <= 1'b0;
         ovf_reg        <= 1'b0;
         w_reg          <= 1'b0;
         t_reg          <= 15'd0;
         v_reg          <= 15'd0;
         x_reg          <= 3'd0;
         oam_addr_reg   <= 8'h00;
         buf_reg        <= 8'h00;
         vram_addr_reg  <= 14'd0;
         vram_wdata_reg <= 8'h00;
         vram_we_reg    <= 1'b0;
         vram_re_reg    <= 1'b0;
      end else begin
         ctrl_reg       <= ctrl_next;
         mask_reg       <= mask_next;
         vblank_reg     <= vblank_next;
         spr0_reg       <= spr0_next;
         ovf_reg        <= ovf_next;
         w_reg          <= w_next;
         t_reg          <= t_next;
         v_reg          <= v_next;
         x_reg          <= x_next;
         oam_addr_reg   <= oam_addr_next;
         buf_reg        <= buf_next;
         vram_addr_reg  <= vram_addr_next;
         vram_wdata_reg <= vram_wdata_next;
         vram_we_reg    <= vram_we_next;
         vram_re_reg    <= vram_re_next;
      end
   end

   assign nmi_o        = ctrl_reg[7] & vblank_reg;
   assign ctrl_o       = ctrl_reg;
   assign mask_o       = mask_reg;
   assign v_o          = v_reg;
   assign t_o          = t_reg;
   assign fine_x_o     = x_reg;
   assign oam_addr_o   = oam_addr_reg;
   assign oam_we_o     = wr && (reg_sel == 3'd4);
   assign oam_wdata_o  = cpu_data_i;
   assign vram_addr_o  = vram_addr_reg;
   assign vram_we_o    = vram_we_reg;
   assign vram_re_o    = vram_re_reg;
   assign vram_wdata_o = vram_wdata_reg;

endmodule
